// File: rtl/reg_wb_ctrl_if.sv
// Writeback controller bus: issue/hazard query, ALU and LSU result inputs, register-file write port.
// master drives issue/results and consumes hazards and rf_*; slave is the controller itself.
interface reg_wb_ctrl_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        haz_a;
  logic        haz_b;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_adr;
  logic [31:0] rf_data;
  logic        err_dup;

  modport master (
    output iss_valid, iss_rd, src_a, src_b,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  haz_a, haz_b, lsu_ready, wb_stall,
    input  rf_we, rf_adr, rf_data, err_dup
  );

  modport slave (
    input  iss_valid, iss_rd, src_a, src_b,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output haz_a, haz_b, lsu_ready, wb_stall,
    output rf_we, rf_adr, rf_data, err_dup
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Writeback arbiter (ALU over buffered loads) driving the single register-file write port, plus busy scoreboard.
// Latency: ALU 1 cycle, load 2 cycles from an empty FIFO; ALU never stalled, LSU back-pressured via lsu_ready.
module reg_wb_ctrl #(
  parameter int LSU_DEPTH = 2
) (
  input logic        clk,
  input logic        reset,
  reg_wb_ctrl_if.slave bus
);
  localparam int PW = $clog2(LSU_DEPTH);
  localparam int CW = $clog2(LSU_DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  ld_t           mem [LSU_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  logic alu_win;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic iss_set;

  assign alu_win    = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(LSU_DEPTH));
  assign pop        = !alu_win && !fifo_empty;
  // A full FIFO can still accept when its head leaves on the same edge.
  assign bus.lsu_ready = reset && (!fifo_full || pop);
  assign push       = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
  assign iss_set    = bus.iss_valid && (bus.iss_rd != 5'd0);

  assign bus.haz_a = busy[bus.src_a] && (bus.src_a != 5'd0);
  assign bus.haz_b = busy[bus.src_b] && (bus.src_b != 5'd0);

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // Commit clears the bit being written this cycle; a same-cycle reissue overrides it.
  always_comb begin
    busy_nxt = busy;
    if (bus.rf_we) busy_nxt[bus.rf_adr] = 1'b0;
    if (iss_set)   busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      busy         <= '0;
      bus.wb_stall <= 1'b0;
      bus.err_dup  <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_adr   <= 5'd0;
      bus.rf_data  <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      busy         <= busy_nxt;
      bus.wb_stall <= (count_nxt >= CW'(LSU_DEPTH - 1));
      if (iss_set && busy[bus.iss_rd]) bus.err_dup <= 1'b1;

      if (alu_win) begin
        bus.rf_we   <= 1'b1;
        bus.rf_adr  <= bus.alu_rd;
        bus.rf_data <= bus.alu_data;
      end else if (pop) begin
        bus.rf_we   <= 1'b1;
        bus.rf_adr  <= mem[rd_ptr].rd;
        bus.rf_data <= mem[rd_ptr].data;
      end else begin
        bus.rf_we   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: expected register writes go into a queue, a negedge monitor checks rf_* against it.
module tb_reg_wb_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  typedef struct packed {
    logic [4:0]  adr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  reg_wb_ctrl_if bus ();

  reg_wb_ctrl #(.LSU_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] adr, input logic [31:0] data);
    exp_q.push_back('{adr: adr, data: data});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'd0;
  endtask

  // Scoreboard monitor: every registered write must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got adr=%0d data=0x%08h expected no write", bus.rf_adr, bus.rf_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.rf_adr !== e.adr || bus.rf_data !== e.data) begin
          n_fail++;
          $display("FAIL wr_order: got adr=%0d data=0x%08h expected adr=%0d data=0x%08h",
                   bus.rf_adr, bus.rf_data, e.adr, e.data);
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.src_a = 5'd0;
    bus.src_b = 5'd0;
    idle();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rf_we",     32'(bus.rf_we),     32'd0);
    chk("rst_rf_adr",    32'(bus.rf_adr),    32'd0);
    chk("rst_rf_data",   bus.rf_data,        32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("rst_wb_stall",  32'(bus.wb_stall),  32'd0);
    chk("rst_err_dup",   32'(bus.err_dup),   32'd0);
    reset = 1'b1;
    #1;
    chk("rel_lsu_ready", 32'(bus.lsu_ready), 32'd1);

    // ALU write to x5 with hazard visibility window
    nxt(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.src_a = 5'd5;
    nxt(); idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    @(negedge clk); chk("t1_haz_issued", 32'(bus.haz_a), 32'd1);
    nxt(); idle();
    @(negedge clk);
    chk("t1_rf_we",      32'(bus.rf_we),  32'd1);
    chk("t1_rf_adr",     32'(bus.rf_adr), 32'd5);
    chk("t1_haz_commit", 32'(bus.haz_a),  32'd1);
    nxt();
    @(negedge clk);
    chk("t1_haz_clear",  32'(bus.haz_a),  32'd0);
    chk("t1_we_low",     32'(bus.rf_we),  32'd0);

    // ALU and load in the same cycle: ALU first, load next
    nxt(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0033;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h12345678;
    expect_wr(5'd3, 32'h0000_0033);
    expect_wr(5'd7, 32'h12345678);
    @(negedge clk); chk("t2_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    nxt(); idle();
    @(negedge clk); chk("t2_alu_adr", 32'(bus.rf_adr), 32'd3);
    nxt();
    @(negedge clk); chk("t2_lsu_adr", 32'(bus.rf_adr), 32'd7);
    nxt();
    @(negedge clk); chk("t2_idle_we", 32'(bus.rf_we), 32'd0);

    // Three back-to-back loads under continuous ALU traffic
    nxt(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h1000_0010;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd20; bus.lsu_data = 32'h2000_0020;
    expect_wr(5'd10, 32'h1000_0010);
    @(negedge clk); chk("t3_ready_0", 32'(bus.lsu_ready), 32'd1);
    nxt(); bus.alu_rd = 5'd11; bus.alu_data = 32'h1000_0011;
    bus.lsu_rd = 5'd21; bus.lsu_data = 32'h2000_0021;
    expect_wr(5'd11, 32'h1000_0011);
    @(negedge clk);
    chk("t3_stall_1", 32'(bus.wb_stall),  32'd1);
    chk("t3_ready_1", 32'(bus.lsu_ready), 32'd1);
    nxt(); bus.alu_rd = 5'd12; bus.alu_data = 32'h1000_0012;
    bus.lsu_rd = 5'd22; bus.lsu_data = 32'h2000_0022;
    expect_wr(5'd12, 32'h1000_0012);
    @(negedge clk); chk("t3_ready_full", 32'(bus.lsu_ready), 32'd0);
    nxt(); idle();
    expect_wr(5'd20, 32'h2000_0020);
    expect_wr(5'd21, 32'h2000_0021);
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("t3_drained_we",    32'(bus.rf_we),    32'd0);
    chk("t3_drained_stall", 32'(bus.wb_stall), 32'd0);
    // Lone load into an empty FIFO: written two cycles after acceptance
    nxt(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd22; bus.lsu_data = 32'h2000_0022;
    expect_wr(5'd22, 32'h2000_0022);
    @(negedge clk); chk("t3_ready_empty", 32'(bus.lsu_ready), 32'd1);
    nxt(); idle();
    @(negedge clk); chk("t3_lat_n1", 32'(bus.rf_we), 32'd0);
    nxt();
    @(negedge clk);
    chk("t3_lat_n2",     32'(bus.rf_we),  32'd1);
    chk("t3_lat_n2_adr", 32'(bus.rf_adr), 32'd22);

    // rd == 0 everywhere: nothing written, nothing busy
    nxt(); bus.src_a = 5'd0; bus.src_b = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_0BAD;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0000_0BAD;
    @(negedge clk); chk("t4_ready", 32'(bus.lsu_ready), 32'd1);
    nxt(); idle();
    @(negedge clk);
    chk("t4_we_n1",  32'(bus.rf_we), 32'd0);
    chk("t4_haz_n1", 32'(bus.haz_a), 32'd0);
    nxt();
    @(negedge clk);
    chk("t4_we_n2",  32'(bus.rf_we), 32'd0);
    chk("t4_haz_n2", 32'(bus.haz_b), 32'd0);

    // Duplicate issue of x9 is sticky
    nxt(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    @(negedge clk); chk("t5_dup_pre", 32'(bus.err_dup), 32'd0);
    nxt();
    @(negedge clk); chk("t5_dup_first", 32'(bus.err_dup), 32'd0);
    nxt(); idle();
    @(negedge clk); chk("t5_dup_set", 32'(bus.err_dup), 32'd1);
    nxt(); nxt();
    @(negedge clk); chk("t5_dup_sticky", 32'(bus.err_dup), 32'd1);

    // Reissue of x4 on its commit cycle keeps it busy
    nxt(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd4; bus.src_b = 5'd4;
    nxt(); idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h0000_0044;
    expect_wr(5'd4, 32'h0000_0044);
    @(negedge clk); chk("t5_x4_busy", 32'(bus.haz_b), 32'd1);
    nxt(); idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    @(negedge clk); chk("t5_x4_commit_adr", 32'(bus.rf_adr), 32'd4);
    nxt(); idle();
    @(negedge clk); chk("t5_set_wins", 32'(bus.haz_b), 32'd1);
    nxt();
    @(negedge clk); chk("t5_set_holds", 32'(bus.haz_b), 32'd1);

    // Asynchronous reset with two loads buffered
    nxt(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd17; bus.src_a = 5'd17;
    nxt(); idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd15; bus.alu_data = 32'h1500_0015;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd25; bus.lsu_data = 32'h2500_0025;
    expect_wr(5'd15, 32'h1500_0015);
    nxt(); bus.alu_rd = 5'd16; bus.alu_data = 32'h1600_0016;
    bus.lsu_rd = 5'd26; bus.lsu_data = 32'h2600_0026;
    expect_wr(5'd16, 32'h1600_0016);
    nxt(); idle();
    @(negedge clk);
    chk("t6_pre_stall", 32'(bus.wb_stall), 32'd1);
    chk("t6_pre_haz",   32'(bus.haz_a),    32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_async_we",    32'(bus.rf_we),     32'd0);
    chk("t6_async_adr",   32'(bus.rf_adr),    32'd0);
    chk("t6_async_haz",   32'(bus.haz_a),     32'd0);
    chk("t6_async_stall", 32'(bus.wb_stall),  32'd0);
    chk("t6_async_ready", 32'(bus.lsu_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rel_ready", 32'(bus.lsu_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(bus.rf_we), 32'd0);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_wb_ctrl.md
# reg_wb_ctrl

Writeback controller for the SELEN CPU core and sole master of the register file's write port (we / adr_wrt / data_in). It merges single-cycle ALU results with variable-latency load returns from the LSU, buffers loads in a small FIFO, and issues at most one register write per cycle. It also keeps a 32-entry busy scoreboard so decode can detect read-after-write hazards on both source operands.

## Interface
- LSU_DEPTH, 2: load-return FIFO depth; power of two, >= 2.

- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- iss_valid  in  1  decode issues an instruction that writes rd.
- iss_rd  in  5  destination register of issued instruction.
- src_a  in  5  decode operand A address for hazard query.
- src_b  in  5  decode operand B address for hazard query.
- haz_a  out  1  combinational: busy[src_a] and src_a != 0.
- haz_b  out  1  combinational: busy[src_b] and src_b != 0.
- alu_valid  in  1  ALU result valid this cycle; cannot be back-pressured.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- lsu_valid  in  1  load data return valid.
- lsu_ready  out  1  FIFO not full; a transfer happens when lsu_valid and lsu_ready.
- lsu_rd  in  5  load destination.
- lsu_data  in  32  load data.
- wb_stall  out  1  registered; high while FIFO holds LSU_DEPTH-1 or more entries; decode holds ALU issue.
- rf_we  out  1  registered write enable to register file.
- rf_adr  out  5  registered write address.
- rf_data  out  32  registered write data.
- err_dup  out  1  sticky: issue targeted an already-busy rd.

## Operation
- Scoreboard busy[31:0]; busy[0] is hardwired 0.
- Issue: iss_valid with iss_rd != 0 sets busy[iss_rd] at the next posedge. If busy[iss_rd] is already 1, err_dup sets and stays set until reset. The busy bit remains 1.
- Arbitration, evaluated each cycle:
  - A valid ALU result with alu_rd != 0 wins unconditionally.
  - Otherwise, if the FIFO is non-empty, pop its head.
  - Otherwise, rf_we=0.
- Results with rd == 0 are discarded: no write, no FIFO entry, no scoreboard change. lsu_valid with lsu_rd == 0 is still accepted and dropped.
- LSU transfer pushes {lsu_rd, lsu_data} into the FIFO. Order is preserved. Push and pop in the same cycle are allowed when the FIFO is full.
- Commit: whenever a write is registered onto rf_*, busy[rf_adr] clears on the same edge on which rf_we deasserts or advances. That is the edge at which the register file captures the data.
- Simultaneous set and clear of the same rd in one cycle: the set wins.
- Pointers wrap modulo LSU_DEPTH. Occupancy is tracked by a count of width clog2(LSU_DEPTH)+1.

## Timing
- Reset values:
  - rf_we=0, rf_adr=0, rf_data=0
  - busy=0, FIFO empty
  - lsu_ready=1 once reset is released; lsu_ready=0 while reset is low
  - wb_stall=0, err_dup=0
- Latency:
  - ALU result presented in cycle N -> rf_we=1 with that data in cycle N+1 -> register file written at the end of N+1.
  - Load accepted in cycle N into an empty FIFO with no ALU contention -> rf_we in cycle N+2.
- A busy bit remains visible through haz_a/haz_b up to and including the cycle in which rf_we is high for that register. It reads 0 from the following cycle.
- Reset asserted mid-operation: in-flight FIFO contents and pending writes are lost, and rf_we drops asynchronously. Reset release is synchronised externally.
- Back-to-back ALU results starve the FIFO. wb_stall bounds this, because decode stops ALU issue while the FIFO is nearly full.

## Test plan
- Reset, then ALU writes x5=0xDEADBEEF at cycle 3 -> rf_we=1, rf_adr=5, rf_data=0xDEADBEEF in cycle 4; haz_a for src_a=5 reads 1 in cycle 4 and 0 in cycle 5.
- Load to x7=0x12345678 while an ALU result to x3 arrives in the same cycle -> x3 is written first, x7 one cycle later; lsu_ready stays 1.
- Three loads back-to-back while ALU is valid every cycle, LSU_DEPTH=2 -> lsu_ready=0 on the third load; wb_stall=1 after the first push; once ALU is idle, writes drain in order.
- Issue rd=0, ALU result rd=0, load rd=0 -> rf_we never asserts, busy stays 0, haz_a for src_a=0 stays 0.
- Issue x9 twice without a commit -> err_dup=1 and it remains 1; issue x4 in the same cycle as the commit of x4 -> busy[4] stays 1.
- Assert reset low asynchronously with the FIFO holding 2 entries -> rf_we, busy and count read 0 before the next clk edge; no stale write after release.
